apuracao_votos: RTL and testbench
=================================

# apuracao_votos

Vote tally and result stage placed directly downstream of `urna`. It consumes the per-candidate vote strobes (`candidatoArthur`, `candidatoLeandro`, `candidatoMateus`, `candidatoPablo`, `candidatoNulo`) and keeps one synchronous saturating BCD counter per strobe. When the poll is closed, it runs a sequential comparison to publish the winner or a tie. It replaces the ripple-clocked `contadorBCD` chains with a single-clock tally.

## Interface
- `DIGITS`, default 4: BCD digits per counter (range 1..6).
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `candidatoArthur`  in  1  vote strobe, candidate code 0.
- `candidatoLeandro`  in  1  vote strobe, code 1.
- `candidatoMateus`  in  1  vote strobe, code 2.
- `candidatoPablo`  in  1  vote strobe, code 3.
- `candidatoNulo`  in  1  null-vote strobe, code 4. Counted, but never eligible to win.
- `finish`  in  1  close poll and start the count (level, sampled).
- `sel`  in  3  read-port select, 0..4. Values 5..7 read as zero.
- `total`  out  4*DIGITS  BCD count of counter `sel`. Combinational from registers.
- `vencedor`  out  3  winning code 0..3, or 7 for none/tie.
- `empate`  out  1  tie for the top count among codes 0..3.
- `done`  out  1  result valid.
- `overflow`  out  1  sticky; a vote arrived at a saturated counter.

## Operation
- Reset (async, `reset`=0):
  - all counters are 0;
  - `vencedor`=7, `empate`=0, `done`=0, `overflow`=0;
  - state is VOTING;
  - strobe history registers are set to 1, so a strobe already high at reset release is not counted.
- Edge detection: each strobe has a history flop. A vote is counted when the input is sampled 1 and the history is 0.
  - A strobe held high for any number of cycles counts exactly once.
- Counters: BCD increment with per-digit carry (9 rolls to 0 with carry).
  - At all-nines, a further vote holds the value and sets `overflow`. `overflow` clears only on reset.
- Simultaneous strobes on different candidates in one cycle: each is counted independently in that cycle.
- FSM states:
  - VOTING: counting enabled. `finish`=1 at an edge moves the FSM to COMPARE, clears the best value and best index, and sets idx=0. Votes detected on that same edge are still counted.
  - COMPARE: counting disabled and strobes ignored; history flops keep tracking. On each edge, counter[idx] is compared against best:
    - if greater, best and best index are updated and the tie flag is cleared;
    - if equal and nonzero, the tie flag is set.
    - After idx=3 the FSM moves to DONE.
  - DONE: registers the result.
    - `done`=1.
    - If best=0: `vencedor`=7, `empate`=0.
    - If tie: `vencedor`=7, `empate`=1.
    - Otherwise: `vencedor`=best index, `empate`=0.
    - DONE is terminal; `finish` and strobes are ignored and only reset leaves it.
- Comparison is a plain unsigned compare on the packed BCD word. This is valid because BCD ordering matches numeric ordering.
- `total` stays readable in every state.

## Timing
- A strobe rising before edge N (sampled at N) is reflected on `total` right after edge N. Latency is 1 edge.
- `finish` sampled high at edge F:
  - COMPARE runs on edges F+1..F+4 (idx 0..3);
  - `done`, `vencedor` and `empate` become valid after edge F+5 and hold until reset.
- A reset assertion mid-COMPARE or mid-DONE immediately clears everything per the reset values above. No partial result survives.
- `finish` during COMPARE has no effect.

## Test plan
- Reset: `reset`=0 for 2 cycles → `total`=0 for `sel`=0..4, `vencedor`=7, `empate`=0, `done`=0, `overflow`=0. A strobe held high across reset release → count stays 0.
- Counting: 3 pulses on Mateus, each 3 cycles wide → `sel`=2 gives `total`=0x0003. 12 single-cycle Arthur pulses → `sel`=0 gives 0x0012. Leandro and Pablo pulsed in the same cycle → both read 1.
- Saturation with `DIGITS`=1: 10 Pablo pulses → `total`=9, `overflow`=1. An 11th pulse → still 9, `overflow` stays 1.
- Winner: Arthur 5, Leandro 2, Mateus 7, Pablo 0, Nulo 20; `finish` at edge F → `done`=1 after F+5, `vencedor`=2, `empate`=0. Later Mateus pulses do not change `total`.
- Tie and empty cases:
  - Arthur 4, Pablo 4, others 0 → `vencedor`=7, `empate`=1.
  - All candidates 0 and Nulo 3 → `vencedor`=7, `empate`=0, `done`=1.
- Reset mid-operation: assert `reset` at F+2 → all outputs return to reset values immediately. After release, one Arthur pulse plus `finish` → `vencedor`=0.

Source files
------------

// File: rtl/apuracao_votos.sv
// apuracao_votos: vote tally and result stage downstream of the ballot box.
// One synchronous saturating BCD counter per vote strobe, edge-detected.
// Closing the poll runs a four-step sequential compare over codes 0..3
// and publishes the winner, a tie, or "no winner".
// Ports:
//   clock, reset            : system clock, async active-low reset
//   candidato*              : vote strobes, codes 0..4 (Nulo = 4, never wins)
//   finish                  : close poll and start the count
//   sel / total             : read port, BCD count of counter sel (5..7 read 0)
//   vencedor/empate/done    : result, valid once done=1
//   overflow                : sticky, a vote hit a saturated counter
module apuracao_votos #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  candidatoArthur,
  input  logic                  candidatoLeandro,
  input  logic                  candidatoMateus,
  input  logic                  candidatoPablo,
  input  logic                  candidatoNulo,
  input  logic                  finish,
  input  logic [2:0]            sel,
  output logic [4*DIGITS-1:0]   total,
  output logic [2:0]            vencedor,
  output logic                  empate,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned NCNT  = 5;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_VOTING  = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NCNT-1:0]   hist_q, hist_d;
  logic [W-1:0]      cnt_q [NCNT];
  logic [W-1:0]      cnt_d [NCNT];
  logic [W-1:0]      best_q, best_d;
  logic [1:0]        best_idx_q, best_idx_d;
  logic [1:0]        idx_q, idx_d;
  logic              tie_q, tie_d;
  logic [2:0]        vencedor_q, vencedor_d;
  logic              empate_q, empate_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;

  logic [NCNT-1:0]   strobe_c;
  logic [NCNT-1:0]   rise_c;
  logic [W-1:0]      cur_c;

  // BCD +1 with per-digit carry; caller handles the all-nines case.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign strobe_c = {candidatoNulo, candidatoPablo, candidatoMateus,
                     candidatoLeandro, candidatoArthur};
  assign rise_c   = strobe_c & ~hist_q;

  // Counter currently under comparison.
  always_comb begin
    cur_c = '0;
    for (int i = 0; i < 4; i++) begin
      if (idx_q == 2'(i)) cur_c = cnt_q[i];
    end
  end

  // Read port; out-of-range selects read as zero.
  always_comb begin
    total = '0;
    for (int i = 0; i < int'(NCNT); i++) begin
      if (sel == 3'(i)) total = cnt_q[i];
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d    = state_q;
    hist_d     = strobe_c;
    for (int i = 0; i < int'(NCNT); i++) cnt_d[i] = cnt_q[i];
    best_d     = best_q;
    best_idx_d = best_idx_q;
    idx_d      = idx_q;
    tie_d      = tie_q;
    vencedor_d = vencedor_q;
    empate_d   = empate_q;
    done_d     = done_q;
    overflow_d = overflow_q;

    case (state_q)
      S_VOTING: begin
        for (int i = 0; i < int'(NCNT); i++) begin
          if (rise_c[i]) begin
            if (cnt_q[i] == ALL_NINES) overflow_d = 1'b1;
            else                       cnt_d[i]   = bcd_inc(cnt_q[i]);
          end
        end
        if (finish) begin
          state_d    = S_COMPARE;
          best_d     = '0;
          best_idx_d = 2'd0;
          tie_d      = 1'b0;
          idx_d      = 2'd0;
        end
      end
      S_COMPARE: begin
        // Packed BCD compares correctly as plain unsigned.
        if (cur_c > best_q) begin
          best_d     = cur_c;
          best_idx_d = idx_q;
          tie_d      = 1'b0;
        end else if ((cur_c == best_q) && (cur_c != '0)) begin
          tie_d = 1'b1;
        end
        if (idx_q == 2'd3) state_d = S_DONE;
        else               idx_d   = idx_q + 2'd1;
      end
      S_DONE: begin
        done_d = 1'b1;
        if (best_q == '0) begin
          vencedor_d = 3'd7;
          empate_d   = 1'b0;
        end else if (tie_q) begin
          vencedor_d = 3'd7;
          empate_d   = 1'b1;
        end else begin
          vencedor_d = {1'b0, best_idx_q};
          empate_d   = 1'b0;
        end
      end
      default: state_d = S_VOTING;
    endcase
  end

  // State register; history resets high so a held strobe is not counted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_VOTING;
      hist_q     <= '1;
      for (int i = 0; i < int'(NCNT); i++) cnt_q[i] <= '0;
      best_q     <= '0;
      best_idx_q <= 2'd0;
      idx_q      <= 2'd0;
      tie_q      <= 1'b0;
      vencedor_q <= 3'd7;
      empate_q   <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      for (int i = 0; i < int'(NCNT); i++) cnt_q[i] <= cnt_d[i];
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      idx_q      <= idx_d;
      tie_q      <= tie_d;
      vencedor_q <= vencedor_d;
      empate_q   <= empate_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign vencedor = vencedor_q;
  assign empate   = empate_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_apuracao_votos.sv
// Testbench for apuracao_votos: vote counts kept as plain integers,
// expected totals and results derived from them arithmetically.
module tb_apuracao_votos;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  strb;
  logic        fin;
  logic [2:0]  sel;
  logic [15:0] total;
  logic [2:0]  venc;
  logic        emp, done, ovf;

  logic [4:0]  strb1;
  logic        fin1;
  logic [2:0]  sel1;
  logic [3:0]  total1;
  logic [2:0]  venc1;
  logic        emp1, done1, ovf1;

  int checks   = 0;
  int failures = 0;
  int m_cnt[5];

  always #5 clk = ~clk;

  apuracao_votos #(.DIGITS(4)) dut (
    .clock(clk), .reset(rst_n),
    .candidatoArthur(strb[0]), .candidatoLeandro(strb[1]),
    .candidatoMateus(strb[2]), .candidatoPablo(strb[3]),
    .candidatoNulo(strb[4]), .finish(fin), .sel(sel),
    .total(total), .vencedor(venc), .empate(emp), .done(done),
    .overflow(ovf)
  );

  apuracao_votos #(.DIGITS(1)) dut1 (
    .clock(clk), .reset(rst_n),
    .candidatoArthur(strb1[0]), .candidatoLeandro(strb1[1]),
    .candidatoMateus(strb1[2]), .candidatoPablo(strb1[3]),
    .candidatoNulo(strb1[4]), .finish(fin1), .sel(sel1),
    .total(total1), .vencedor(venc1), .empate(emp1), .done(done1),
    .overflow(ovf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    int v;
    logic [15:0] r;
    v = (n > 9999) ? 9999 : n;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // Expected result: largest count among candidates 0..3.
  task automatic exp_result(output logic [2:0] ev, output logic ee);
    int best, n, bi;
    best = 0; n = 0; bi = 0;
    for (int i = 0; i < 4; i++) if (m_cnt[i] > best) begin best = m_cnt[i]; bi = i; end
    for (int i = 0; i < 4; i++) if (m_cnt[i] == best) n++;
    if (best == 0)   begin ev = 3'd7; ee = 1'b0; end
    else if (n > 1)  begin ev = 3'd7; ee = 1'b1; end
    else             begin ev = 3'(bi); ee = 1'b0; end
  endtask

  task automatic do_reset();
    strb = '0; fin = 1'b0; strb1 = '0; fin1 = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
  endtask

  // Raise strobes in mask for width cycles, then drop for one cycle.
  task automatic pulse(input logic [4:0] mask, input int width, input bit count_it);
    strb = mask;
    repeat (width) tick();
    strb = '0;
    tick();
    if (count_it) for (int i = 0; i < 5; i++) if (mask[i]) m_cnt[i]++;
  endtask

  task automatic votes(input int a, input int l, input int m, input int p, input int n);
    int c[5];
    c[0] = a; c[1] = l; c[2] = m; c[3] = p; c[4] = n;
    for (int i = 0; i < 5; i++) repeat (c[i]) pulse(5'(1 << i), 1, 1'b1);
  endtask

  // finish sampled at edge F; returns done as seen after F+4, leaves after F+5.
  task automatic run_finish(output logic early_done);
    fin = 1'b1;
    tick();
    fin = 1'b0;
    repeat (4) tick();
    early_done = done;
    tick();
  endtask

  task automatic test_reset();
    strb = '0; fin = 1'b0; strb1 = '0; fin1 = 1'b0; sel1 = 3'd3;
    rst_n = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      sel = 3'(i); #1;
      checks++;
      if (total !== 16'h0) begin failures++; $display("FAIL reset_total[%0d] got=%h exp=0000", i, total); end
    end
    checks++;
    if (venc !== 3'd7 || emp !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got venc=%0d emp=%b done=%b ovf=%b exp 7/0/0/0", venc, emp, done, ovf);
    end
    // Strobe held high across reset release must not count.
    strb = 5'b00001;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    strb = '0;
    tick();
    sel = 3'd0; #1;
    checks++;
    if (total !== 16'h0) begin failures++; $display("FAIL held_strobe got=%h exp=0000", total); end
  endtask

  task automatic test_counting();
    do_reset();
    repeat (3) pulse(5'b00100, 3, 1'b1);
    repeat (12) pulse(5'b00001, 1, 1'b1);
    pulse(5'b01010, 1, 1'b1);
    // One-edge latency: the first edge that samples the strobe updates total.
    sel = 3'd4;
    strb = 5'b10000;
    tick();
    m_cnt[4]++;
    checks++;
    if (total !== to_bcd(m_cnt[4])) begin failures++; $display("FAIL latency got=%h exp=%h", total, to_bcd(m_cnt[4])); end
    strb = '0;
    tick();
    sel = 3'd2; #1;
    checks++;
    if (total !== 16'h0003) begin failures++; $display("FAIL mateus_wide got=%h exp=0003", total); end
    sel = 3'd0; #1;
    checks++;
    if (total !== 16'h0012) begin failures++; $display("FAIL arthur_12 got=%h exp=0012", total); end
    for (int k = 0; k < 20; k++) pulse(5'($urandom_range(1, 31)), $urandom_range(1, 3), 1'b1);
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i); #1;
      checks++;
      if (total !== ((i < 5) ? to_bcd(m_cnt[i]) : 16'h0)) begin
        failures++;
        $display("FAIL count_total[%0d] got=%h exp=%h", i, total, (i < 5) ? to_bcd(m_cnt[i]) : 16'h0);
      end
    end
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL count_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_saturation();
    do_reset();
    sel1 = 3'd3;
    for (int k = 1; k <= 11; k++) begin
      strb1 = 5'b01000; tick();
      strb1 = '0;       tick();
      if (k == 9 || k == 10 || k == 11) begin
        checks++;
        if (total1 !== 4'd9 || ovf1 !== (k >= 10)) begin
          failures++;
          $display("FAIL sat_pulse%0d got total=%0d ovf=%b exp total=9 ovf=%b", k, total1, ovf1, k >= 10);
        end
      end
    end
  endtask

  task automatic test_winner();
    logic [2:0] ev; logic ee, early;
    do_reset();
    votes(5, 2, 7, 0, 20);
    exp_result(ev, ee);
    run_finish(early);
    checks++;
    if (early !== 1'b0) begin failures++; $display("FAIL winner_early_done got=%b exp=0", early); end
    checks++;
    if (done !== 1'b1 || venc !== 3'd2 || emp !== 1'b0 || ev !== 3'd2) begin
      failures++;
      $display("FAIL winner got done=%b venc=%0d emp=%b exp 1/%0d/%b", done, venc, emp, ev, ee);
    end
    fin = 1'b1;
    pulse(5'b00100, 1, 1'b0);
    fin = 1'b0;
    sel = 3'd2; #1;
    checks++;
    if (total !== 16'h0007 || venc !== 3'd2 || done !== 1'b1) begin
      failures++;
      $display("FAIL after_done got total=%h venc=%0d done=%b exp 0007/2/1", total, venc, done);
    end
  endtask

  task automatic test_tie_empty();
    logic early;
    do_reset();
    votes(4, 0, 0, 4, 0);
    run_finish(early);
    checks++;
    if (venc !== 3'd7 || emp !== 1'b1 || done !== 1'b1) begin
      failures++; $display("FAIL tie got venc=%0d emp=%b done=%b exp 7/1/1", venc, emp, done);
    end
    do_reset();
    votes(0, 0, 0, 0, 3);
    run_finish(early);
    checks++;
    if (venc !== 3'd7 || emp !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL empty got venc=%0d emp=%b done=%b exp 7/0/1", venc, emp, done);
    end
  endtask

  task automatic test_random();
    logic [2:0] ev; logic ee, early;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int k = 0; k < 15; k++) pulse(5'($urandom_range(1, 31)), $urandom_range(1, 2), 1'b1);
      if (it == 5) begin  // force an exact tie among the front-runners
        m_cnt[1] = 0; m_cnt[3] = 0;
      end
      if (it == 5) begin
        do_reset();
        votes(3, 6, 2, 6, 1);
      end
      exp_result(ev, ee);
      run_finish(early);
      checks++;
      if (done !== 1'b1 || venc !== ev || emp !== ee) begin
        failures++;
        $display("FAIL random%0d got done=%b venc=%0d emp=%b exp 1/%0d/%b", it, done, venc, emp, ev, ee);
      end
      for (int i = 0; i < 5; i++) begin
        sel = 3'(i); #1;
        checks++;
        if (total !== to_bcd(m_cnt[i])) begin
          failures++; $display("FAIL random%0d_total[%0d] got=%h exp=%h", it, i, total, to_bcd(m_cnt[i]));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic early;
    do_reset();
    votes(2, 1, 0, 0, 0);
    fin = 1'b1;
    tick();          // edge F
    fin = 1'b0;
    repeat (2) tick();  // F+2
    rst_n = 1'b0;
    #1;
    sel = 3'd0; #1;
    checks++;
    if (total !== 16'h0 || venc !== 3'd7 || emp !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got total=%h venc=%0d emp=%b done=%b ovf=%b exp 0000/7/0/0/0", total, venc, emp, done, ovf);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    votes(1, 0, 0, 0, 0);
    run_finish(early);
    checks++;
    if (venc !== 3'd0 || emp !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL after_mid_reset got venc=%0d emp=%b done=%b exp 0/0/1", venc, emp, done);
    end
  endtask

  initial begin
    sel = 3'd0;
    test_reset();
    test_counting();
    test_saturation();
    test_winner();
    test_tie_empty();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
